// File: rtl/lif_layer_seq.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons with binary weights.
// One neuron is updated per clock from a snapshot of the byte-serially loaded input vector.
module lif_layer_seq #(
    parameter int INPUTS     = 32,
    parameter int NEURONS    = 4,
    parameter int U_BITS     = 8,
    parameter int SHIFT_BITS = 3,
    parameter int REF_BITS   = 2,
    localparam int AW        = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int S_W       = $clog2(INPUTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x_valid,
    input  logic [7:0]            x_byte,
    input  logic                  w_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [INPUTS-1:0]     w_data,
    input  logic                  shift_we,
    input  logic [SHIFT_BITS-1:0] shift_data,
    input  logic                  theta_we,
    input  logic [U_BITS-1:0]     theta_data,
    input  logic [REF_BITS-1:0]   ref_period,
    input  logic                  step_start,
    output logic                  busy,
    output logic                  out_valid,
    output logic [NEURONS-1:0]    spikes,
    output logic [U_BITS-1:0]     u_mon,
    output logic [1:0]            state_dbg
);

    localparam int SUM_W = ((U_BITS > S_W) ? U_BITS : S_W) + 1;
    localparam logic [SUM_W-1:0] U_MAX = SUM_W'((1 << (U_BITS - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [INPUTS-1:0]       x_reg, xs;
    logic [INPUTS-1:0]       w_mem   [NEURONS];
    logic [SHIFT_BITS-1:0]   sh_mem  [NEURONS];
    logic signed [U_BITS-1:0] u_mem  [NEURONS];
    logic [REF_BITS-1:0]     cnt_mem [NEURONS];
    logic [U_BITS-1:0]       theta;
    logic [REF_BITS-1:0]     ref_lat;
    logic [AW-1:0]           idx;
    logic [NEURONS-1:0]      spk_acc;

    logic                    start_ok, cfg_ok, last, addr_ok;
    logic signed [U_BITS-1:0] u_cur, ul, ua, u_next;
    logic [SHIFT_BITS-1:0]   sh_cur;
    logic [REF_BITS-1:0]     cnt_cur, cnt_next;
    logic [S_W-1:0]          s_cnt;
    logic [SUM_W-1:0]        sum;
    logic                    fire;

    function automatic logic [S_W-1:0] popcount(input logic [INPUTS-1:0] v);
        logic [S_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < INPUTS; i++) begin
            acc = acc + S_W'(v[i]);
        end
        return acc;
    endfunction

    // Handshake: step_start is a request taken only in IDLE or in the out_valid
    // cycle; busy covers the EVAL cycles and out_valid is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        last      = (idx == AW'(NEURONS - 1));
        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    start_ok = 1'b1;
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                busy = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (step_start) begin
                    start_ok = 1'b1;
                    state_d  = S_EVAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A write coinciding with an accepted step_start is dropped so the step sees old values.
    assign cfg_ok    = (state_q == S_IDLE) && !step_start;
    assign addr_ok   = ({1'b0, cfg_addr} < (AW + 1)'(NEURONS));
    assign u_mon     = addr_ok ? u_mem[cfg_addr] : '0;
    assign state_dbg = state_q;

    always_comb begin
        u_cur   = u_mem[idx];
        sh_cur  = sh_mem[idx];
        cnt_cur = cnt_mem[idx];
        s_cnt   = popcount(w_mem[idx] & xs);
        ul      = u_cur - (u_cur >>> sh_cur);
        // ul is never negative because u stays >= 0, so the sum is done unsigned.
        sum     = SUM_W'($unsigned(ul)) + SUM_W'(s_cnt);
        ua      = (sum > U_MAX) ? U_MAX[U_BITS-1:0] : sum[U_BITS-1:0];
        fire    = 1'b0;
        u_next  = ua;
        cnt_next = cnt_cur;
        if (cnt_cur != '0) begin
            u_next   = '0;
            cnt_next = cnt_cur - 1'b1;
        end else if (ua >= $signed(theta)) begin
            fire     = 1'b1;
            u_next   = ua - $signed(theta);
            cnt_next = ref_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_reg   <= '0;
            xs      <= '0;
            theta   <= U_BITS'(5);
            ref_lat <= '0;
            idx     <= '0;
            spk_acc <= '0;
            spikes  <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                w_mem[n]   <= '0;
                sh_mem[n]  <= '0;
                u_mem[n]   <= '0;
                cnt_mem[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (x_valid) x_reg <= INPUTS'({x_reg, x_byte});
            if (start_ok) begin
                xs      <= x_reg;
                ref_lat <= ref_period;
                idx     <= '0;
                spk_acc <= '0;
            end
            if (state_q == S_EVAL) begin
                u_mem[idx]   <= u_next;
                cnt_mem[idx] <= cnt_next;
                spk_acc[idx] <= fire;
                idx          <= idx + 1'b1;
                if (last) spikes <= spk_acc | (NEURONS'(fire) << idx);
            end
            if (cfg_ok) begin
                if (w_we && addr_ok)     w_mem[cfg_addr]  <= w_data;
                if (shift_we && addr_ok) sh_mem[cfg_addr] <= shift_data;
                if (theta_we)            theta            <= theta_data;
            end
        end
    end

endmodule

// File: tb/tb_lif_layer_seq.sv
// Bench for lif_layer_seq: a whole-step arithmetic model predicts spikes, membranes
// and handshake timing; directed tests pin the model with hand-computed values.
module tb_lif_layer_seq;

    localparam int INPUTS  = 32;
    localparam int NEURONS = 4;
    localparam int U_BITS  = 8;
    localparam int AW      = 2;
    localparam int U_MAX   = (1 << (U_BITS - 1)) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              x_valid = 1'b0;
    logic [7:0]        x_byte = '0;
    logic              w_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [INPUTS-1:0] w_data = '0;
    logic              shift_we = 1'b0;
    logic [2:0]        shift_data = '0;
    logic              theta_we = 1'b0;
    logic [7:0]        theta_data = '0;
    logic [1:0]        ref_period = '0;
    logic              step_start = 1'b0;
    logic              busy, out_valid;
    logic [NEURONS-1:0] spikes;
    logic [7:0]        u_mon;
    logic [1:0]        state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    lif_layer_seq #(.INPUTS(INPUTS), .NEURONS(NEURONS), .U_BITS(U_BITS),
                    .SHIFT_BITS(3), .REF_BITS(2)) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x_byte(x_byte),
        .w_we(w_we), .cfg_addr(cfg_addr), .w_data(w_data),
        .shift_we(shift_we), .shift_data(shift_data),
        .theta_we(theta_we), .theta_data(theta_data),
        .ref_period(ref_period), .step_start(step_start),
        .busy(busy), .out_valid(out_valid), .spikes(spikes),
        .u_mon(u_mon), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int                m_u[NEURONS];
    int                m_cnt[NEURONS];
    int                m_shift[NEURONS];
    logic [INPUTS-1:0] m_w[NEURONS];
    logic [INPUTS-1:0] m_x;
    int                m_theta;
    int                m_phase;  // 0 idle, 1..NEURONS evaluating, NEURONS+1 result cycle
    logic [NEURONS-1:0] m_spikes, m_pending;
    bit                m_accept, m_cfg;

    task automatic model_step(input int rp);
        for (int n = 0; n < NEURONS; n++) begin
            int s, ul, ua;
            s = $countones(m_w[n] & m_x);
            m_pending[n] = 1'b0;
            if (m_cnt[n] > 0) begin
                m_u[n] = 0;
                m_cnt[n] = m_cnt[n] - 1;
            end else begin
                ul = m_u[n] - (m_u[n] >> m_shift[n]);
                ua = ul + s;
                if (ua > U_MAX) ua = U_MAX;
                if (ua >= m_theta) begin
                    m_pending[n] = 1'b1;
                    m_u[n] = ua - m_theta;
                    m_cnt[n] = rp;
                end else begin
                    m_u[n] = ua;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NEURONS; n++) begin
                m_u[n] = 0; m_cnt[n] = 0; m_shift[n] = 0; m_w[n] = '0;
            end
            m_x = '0; m_theta = 5; m_phase = 0; m_spikes = '0; m_pending = '0;
        end else begin
            m_accept = step_start && (m_phase == 0 || m_phase == NEURONS + 1);
            m_cfg    = (m_phase == 0) && !step_start;
            if (m_accept) model_step(int'(ref_period));
            if (m_cfg) begin
                if (w_we)     m_w[cfg_addr] = w_data;
                if (shift_we) m_shift[cfg_addr] = int'(shift_data);
                if (theta_we) m_theta = int'(theta_data);
            end
            if (x_valid) m_x = {m_x[INPUTS-9:0], x_byte};
            if (m_accept)                   m_phase = 1;
            else if (m_phase == NEURONS + 1) m_phase = 0;
            else if (m_phase > 0)           m_phase = m_phase + 1;
            if (m_phase == NEURONS + 1) m_spikes = m_pending;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", out_valid, 64'(m_phase == NEURONS + 1));
            check("spikes", spikes, 64'(m_spikes));
            if (m_phase == 0) begin
                check("busy_idle", busy, 64'(0));
                check("u_mon", u_mon, 64'(m_u[cfg_addr]));
            end else if (m_phase <= NEURONS) begin
                check("busy_eval", busy, 64'(1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int n, input logic [INPUTS-1:0] d);
        cfg_addr = AW'(n); w_data = d; w_we = 1'b1; tick(); w_we = 1'b0;
    endtask

    task automatic write_shift(input int n, input logic [2:0] d);
        cfg_addr = AW'(n); shift_data = d; shift_we = 1'b1; tick(); shift_we = 1'b0;
    endtask

    task automatic write_theta(input logic [7:0] d);
        theta_data = d; theta_we = 1'b1; tick(); theta_we = 1'b0;
    endtask

    task automatic load_x(input logic [31:0] v);
        for (int b = 3; b >= 0; b--) begin
            x_valid = 1'b1; x_byte = v[b*8 +: 8]; tick();
        end
        x_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge of the out_valid cycle.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_valid_timeout at %0t: got no pulse, want one within 40 cycles", $time);
        end
    endtask

    task automatic run_step(input logic [1:0] rp, output int lat);
        ref_period = rp; step_start = 1'b1; tick(); step_start = 1'b0;
        wait_done(lat);
        tick();
    endtask

    task automatic check_u(input int n, input int exp);
        cfg_addr = AW'(n);
        @(negedge clk);
        check($sformatf("u_lit[%0d]", n), u_mon, 64'(exp));
        tick();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2;
        tick(); tick();
        reset = 1'b0;
        started = 1'b1;
        check("reset_spikes", spikes, 64'(0));
        check("reset_busy", busy, 64'(0));
        check("reset_out_valid", out_valid, 64'(0));
        check_u(0, 0);

        // Integrate below threshold, then spike with refractory period 2.
        write_w(0, '1);
        load_x(32'h0000_0007);
        run_step(2'd0, lat);
        check("latency", lat, 64'(NEURONS + 1));
        check("spk0_a", spikes[0], 64'(0));
        check_u(0, 3);
        load_x(32'h0000_003F);
        run_step(2'd2, lat);
        check("spk0_b", spikes[0], 64'(1));
        check_u(0, 1);
        run_step(2'd2, lat);
        check("spk0_ref1", spikes[0], 64'(0));
        check_u(0, 0);
        run_step(2'd2, lat);
        check("spk0_ref2", spikes[0], 64'(0));
        check_u(0, 0);
        run_step(2'd0, lat);
        check("spk0_after_ref", spikes[0], 64'(1));

        // Leak on neuron 1.
        write_w(1, '1);
        load_x(32'h0000_0007);
        run_step(2'd0, lat);
        check_u(1, 3);
        write_shift(1, 3'd1);
        load_x(32'h0);
        run_step(2'd0, lat); check_u(1, 2);
        run_step(2'd0, lat); check_u(1, 1);
        run_step(2'd0, lat); check_u(1, 1);
        write_shift(1, 3'd7);
        load_x(32'h0000_0003);
        run_step(2'd0, lat);
        check("spk1_a", spikes[1], 64'(0));
        check_u(1, 3);
        run_step(2'd0, lat);
        check("spk1_b", spikes[1], 64'(1));
        check_u(1, 0);

        // Saturation at the top of the signed range.
        write_theta(8'd127);
        write_w(2, '1);
        write_shift(2, 3'd7);
        load_x(32'hFFFF_FFFF);
        run_step(2'd0, lat); check_u(2, 32);
        run_step(2'd0, lat); check_u(2, 64);
        run_step(2'd0, lat); check_u(2, 96);
        check("spk2_pre", spikes[2], 64'(0));
        run_step(2'd0, lat);
        check("spk2_sat", spikes[2], 64'(1));
        check_u(2, 0);

        // Input bytes arriving mid-step go to x, not to the step's snapshot.
        load_x(32'h0);
        ref_period = 2'd0; step_start = 1'b1; tick(); step_start = 1'b0;
        load_x(32'h0000_00FF);
        wait_done(lat);
        tick();
        check_u(2, 0);
        run_step(2'd0, lat);
        check_u(2, 8);

        // step_start held three cycles and a weight write during EVAL.
        ref_period = 2'd0; step_start = 1'b1; tick();
        cfg_addr = AW'(3); w_data = '1; w_we = 1'b1; tick(); tick();
        step_start = 1'b0; w_we = 1'b0;
        wait_done(lat);
        tick();
        run_step(2'd0, lat);
        check_u(3, 0);

        // Back-to-back steps.
        write_theta(8'd5);
        ref_period = 2'd0; step_start = 1'b1; tick(); step_start = 1'b0;
        wait_done(lat);
        check("b2b_lat1", lat, 64'(NEURONS + 1));
        step_start = 1'b1; tick(); step_start = 1'b0;
        wait_done(lat2);
        check("b2b_lat2", lat2, 64'(NEURONS + 1));
        tick();
        check("b2b_spk0", spikes[0], 64'(1));

        // Reset in the middle of a step.
        ref_period = 2'd0; step_start = 1'b1; tick(); step_start = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (NEURONS + 4) tick();
        check("rst_mid_spikes", spikes, 64'(0));
        check("rst_mid_busy", busy, 64'(0));
        check_u(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
